// File: rtl/gbc_cart_pkg.sv
// gbc_cart_pkg: shared types for the GamePak bus sequencer.
// Sequencer states, T-state phase type and external RAM window decode.
package gbc_cart_pkg;

  typedef enum logic [2:0] {
    S_HOLD,
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_ACK
  } seq_state_t;

  typedef logic [1:0] t_phase_t;

  localparam logic [15:0] EXT_CS_LO = 16'hA000;
  localparam logic [15:0] EXT_CS_HI = 16'hFDFF;

  function automatic logic in_ext_window(input logic [15:0] a);
    return (a >= EXT_CS_LO) && (a <= EXT_CS_HI);
  endfunction

endpackage

// File: rtl/gbc_tstate_timer.sv
// gbc_tstate_timer: free-running T-state prescaler and machine-cycle phase.
// TEndNext flags that the following clock will be the last of its T-state.
module gbc_tstate_timer
  import gbc_cart_pkg::*;
#(
  parameter int TPT = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       TEnd,
  output logic       TEndNext,
  output logic [1:0] Phase,
  output logic       MEnd
);

  localparam logic [7:0] PRESC_MAX = 8'(TPT - 1);

  logic [7:0] presc_q, presc_d;
  t_phase_t   phase_q, phase_d;

  // Prescaler wraps at TPT-1; phase advances 0..3 on each T-state end
  always_comb begin
    TEnd     = (presc_q == PRESC_MAX);
    presc_d  = TEnd ? 8'd0 : presc_q + 8'd1;
    phase_d  = TEnd ? phase_q + 2'd1 : phase_q;
    TEndNext = (presc_d == PRESC_MAX);
    MEnd     = TEnd && (phase_q == 2'd3);
  end

  // Timer state registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_q <= 8'd0;
      phase_q <= 2'd0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
    end
  end

  assign Phase = phase_q;

endmodule

// File: rtl/gbc_cart_bus_sequencer.sv
// gbc_cart_bus_sequencer: turns single-word requests into GamePak bus
// cycles and holds the cartridge in reset after system reset.
module gbc_cart_bus_sequencer
  import gbc_cart_pkg::*;
#(
  parameter int TPT        = 8,
  parameter int RESET_HOLD = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [7:0]  WData,
  output logic        Ack,
  output logic [7:0]  RData,
  output logic        Busy,
  output logic        PakClk,
  output logic        PakWrite,
  output logic        PakRead,
  output logic        PakCS,
  output logic [15:0] PakAddr,
  output logic [7:0]  PakDataOut,
  output logic        PakDataOE,
  input  logic [7:0]  PakDataIn,
  output logic        PakReset
);

  localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);
  localparam logic [15:0] HOLD_MAX  = 16'(RESET_HOLD);

  logic     t_end, t_end_next, m_end;
  t_phase_t phase, phase_n;

  gbc_tstate_timer #(.TPT(TPT)) u_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .TEnd     (t_end),
    .TEndNext (t_end_next),
    .Phase    (phase),
    .MEnd     (m_end)
  );

  seq_state_t  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  dout_q, dout_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        pclk_q, pclk_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic        prst_q, prst_d;
  logic        accept, active_n;

  // Next state plus outputs registered from the state being entered
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    hold_d  = hold_q;
    if (t_end && hold_q != HOLD_MAX) hold_d = hold_q + 16'd1;

    unique case (state_q)
      S_HOLD: if (t_end && hold_q == HOLD_LAST) state_d = S_IDLE;
      S_IDLE: begin
        if (Req && m_end) begin
          accept  = 1'b1;
          state_d = S_T0;
        end
      end
      S_T0:  if (t_end) state_d = S_T1;
      S_T1:  if (t_end) state_d = S_T2;
      S_T2:  if (t_end) state_d = S_T3;
      S_T3:  if (t_end) state_d = S_ACK;
      S_ACK: state_d = S_IDLE;
      default: state_d = S_HOLD;
    endcase

    wr_d    = accept ? Wr : wr_q;
    wdata_d = accept ? WData : wdata_q;
    addr_d  = accept ? Addr : addr_q;
    rdata_d = (state_q == S_T3 && t_end && !wr_q) ? PakDataIn : rdata_q;

    phase_n  = t_end ? phase + 2'd1 : phase;
    active_n = state_d inside {S_T0, S_T1, S_T2, S_T3};

    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
    prst_d = (state_d == S_HOLD);
    pclk_d = (phase_n < 2'd2);
    re_d   = active_n && !wr_d;
    oe_d   = active_n && wr_d;
    dout_d = oe_d ? wdata_d : 8'h00;
    cs_d   = (state_d inside {S_T1, S_T2, S_T3}) && in_ext_window(addr_d);
    we_d   = wr_d && ((state_d == S_T2) ||
                      (state_d == S_T3 && !t_end_next));
  end

  // Sequencer registers; reset drops every strobe at once
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_HOLD;
      hold_q  <= 16'd0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      addr_q  <= 16'h0000;
      rdata_q <= 8'h00;
      dout_q  <= 8'h00;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
      pclk_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
      prst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      pclk_q  <= pclk_d;
      we_q    <= we_d;
      re_q    <= re_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
      prst_q  <= prst_d;
    end
  end

  assign Ack        = ack_q;
  assign RData      = rdata_q;
  assign Busy       = busy_q;
  assign PakClk     = pclk_q;
  assign PakWrite   = we_q;
  assign PakRead    = re_q;
  assign PakCS      = cs_q;
  assign PakAddr    = addr_q;
  assign PakDataOut = dout_q;
  assign PakDataOE  = oe_q;
  assign PakReset   = prst_q;

endmodule
